// File: rtl/instr_realigner.sv
// instr_realigner
//   Sits between instruction fetch and decode. Aligned 32-bit fetch words are
//   split into 16-bit parcels and held in a small circular FIFO. The head of
//   the FIFO is presented as a single instruction: either a 32-bit
//   instruction, which may straddle two fetch words, or an RVC parcel
//   expanded to its RV32I equivalent.
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   fetch_valid_i/fetch_ready_o    fetch word handshake
//   fetch_data_i                   aligned word, parcels {hi, lo}
//   redirect_i/redirect_pc_i       flush the FIFO and restart at a new PC
//   instr_valid_o/instr_ready_i    decode handshake
//   instr_o, instr_pc_o            instruction and its PC
//   compressed_o, illegal_o        instruction flags
module instr_realigner #(
  parameter int unsigned BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          ENABLE_C = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        compressed_o,
  output logic        illegal_o
);
  localparam int unsigned AW = $clog2(BUF_HW);
  localparam logic [AW:0] FREE_TH = (AW+1)'(BUF_HW - 2);

  typedef struct packed {
    logic        illegal;
    logic [31:0] instr;
  } exp_t;

  function automatic exp_t rvc_expand(input logic [15:0] c);
    exp_t        r;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6, i16sp;
    logic [20:0] jimm;
    logic [12:0] bimm;
    logic [9:0]  u4spn;
    logic [6:0]  uw;
    logic [7:0]  usp, ussp;
    rd    = c[11:7];
    rs2   = c[6:2];
    rdp   = {2'b01, c[4:2]};
    rs1p  = {2'b01, c[9:7]};
    imm6  = {{6{c[12]}}, c[12], c[6:2]};
    i16sp = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
    jimm  = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    bimm  = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    u4spn = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    uw    = {c[5], c[12:10], c[6], 2'b00};
    usp   = {c[3:2], c[12], c[6:4], 2'b00};
    ussp  = {c[8:7], c[12:9], 2'b00};
    r.illegal = 1'b0;
    r.instr   = 32'h0;
    case (c[1:0])
      2'b00: case (c[15:13])
        3'b000: begin
          r.instr   = {2'b00, u4spn, 5'd2, 3'b000, rdp, 7'h13};
          r.illegal = (u4spn == 10'd0);  // also catches the all-zero parcel
        end
        3'b010:  r.instr = {5'b0, uw, rs1p, 3'b010, rdp, 7'h03};
        3'b110:  r.instr = {5'b0, uw[6:5], rdp, rs1p, 3'b010, uw[4:0], 7'h23};
        default: r.illegal = 1'b1;
      endcase
      2'b01: case (c[15:13])
        3'b000: r.instr = {imm6, rd, 3'b000, rd, 7'h13};
        3'b001: r.instr = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'h6f};
        3'b010: r.instr = {imm6, 5'd0, 3'b000, rd, 7'h13};
        3'b011: begin
          if (rd == 5'd2) begin
            r.instr   = {i16sp, 5'd2, 3'b000, 5'd2, 7'h13};
            r.illegal = (i16sp == 12'd0);
          end else begin
            r.instr   = {{14{c[12]}}, c[12], c[6:2], rd, 7'h37};
            r.illegal = ({c[12], c[6:2]} == 6'd0);
          end
        end
        3'b100: case (c[11:10])
          2'b00: begin
            r.instr   = {7'h00, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
            r.illegal = c[12];
          end
          2'b01: begin
            r.instr   = {7'h20, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
            r.illegal = c[12];
          end
          2'b10: r.instr = {imm6, rs1p, 3'b111, rs1p, 7'h13};
          default: begin
            // c[12]=1 selects the RV64-only word ops
            r.illegal = c[12];
            case (c[6:5])
              2'b00:   r.instr = {7'h20, rdp, rs1p, 3'b000, rs1p, 7'h33};
              2'b01:   r.instr = {7'h00, rdp, rs1p, 3'b100, rs1p, 7'h33};
              2'b10:   r.instr = {7'h00, rdp, rs1p, 3'b110, rs1p, 7'h33};
              default: r.instr = {7'h00, rdp, rs1p, 3'b111, rs1p, 7'h33};
            endcase
          end
        endcase
        3'b101:  r.instr = {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd0, 7'h6f};
        3'b110:  r.instr = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b000, bimm[4:1], bimm[11], 7'h63};
        default: r.instr = {bimm[12], bimm[10:5], 5'd0, rs1p, 3'b001, bimm[4:1], bimm[11], 7'h63};
      endcase
      2'b10: case (c[15:13])
        3'b000: begin
          r.instr   = {7'h00, c[6:2], rd, 3'b001, rd, 7'h13};
          r.illegal = c[12];
        end
        3'b010: begin
          r.instr   = {4'b0, usp, 5'd2, 3'b010, rd, 7'h03};
          r.illegal = (rd == 5'd0);
        end
        3'b100: begin
          if (!c[12]) begin
            if (rs2 == 5'd0) begin
              r.instr   = {12'h0, rd, 3'b000, 5'd0, 7'h67};
              r.illegal = (rd == 5'd0);
            end else
              r.instr = {7'h00, rs2, 5'd0, 3'b000, rd, 7'h33};
          end else if (rs2 == 5'd0 && rd == 5'd0)
            r.instr = 32'h0010_0073;
          else if (rs2 == 5'd0)
            r.instr = {12'h0, rd, 3'b000, 5'd1, 7'h67};
          else
            r.instr = {7'h00, rs2, rd, 3'b000, rd, 7'h33};
        end
        3'b110:  r.instr = {4'b0, ussp[7:5], rs2, 5'd2, 3'b010, ussp[4:0], 7'h23};
        default: r.illegal = 1'b1;
      endcase
      default: r.illegal = 1'b1;
    endcase
    if (r.illegal) r.instr = {16'h0, c};
    return r;
  endfunction

  logic [BUF_HW-1:0][15:0] buf_q;
  logic [AW-1:0] rd_ptr, wr_ptr, push_n, pop_n;
  logic [AW:0]   count;
  logic [31:0]   pc;
  logic          skip_lo, push, pop, is32, head_ok;
  logic [15:0]   h0, h1;
  exp_t          exp_c;
  logic          unused_pc0;

  assign unused_pc0 = redirect_pc_i[0];

  assign h0      = buf_q[rd_ptr];
  assign h1      = buf_q[rd_ptr + AW'(1)];
  assign is32    = (h0[1:0] == 2'b11);
  assign exp_c   = rvc_expand(h0);
  assign head_ok = is32 ? (count >= (AW+1)'(2)) : (count != '0);

  assign fetch_ready_o = (count <= FREE_TH) && !redirect_i;
  assign push   = fetch_valid_i && fetch_ready_o;
  assign pop    = instr_valid_o && instr_ready_i && !redirect_i;
  assign push_n = push ? (skip_lo ? AW'(1) : AW'(2)) : '0;
  assign pop_n  = pop ? (is32 ? AW'(2) : AW'(1)) : '0;

  // Outputs are read straight off the FIFO head; forced to 0 while in reset.
  assign instr_valid_o = rst_n && head_ok;
  assign instr_pc_o    = rst_n ? pc : 32'h0;
  assign compressed_o  = rst_n && !is32;
  assign illegal_o     = rst_n && !is32 && (ENABLE_C ? exp_c.illegal : 1'b1);
  always_comb begin
    instr_o = 32'h0;
    if (rst_n) begin
      if (is32)          instr_o = {h1, h0};
      else if (ENABLE_C) instr_o = exp_c.instr;
      else               instr_o = {16'h0, h0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc      <= RESET_PC;
      skip_lo <= RESET_PC[1];
    end else if (redirect_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pc      <= {redirect_pc_i[31:1], 1'b0};
      skip_lo <= redirect_pc_i[1];
    end else begin
      if (push) begin
        // A redirect into the upper half of a word drops that word's low parcel.
        if (skip_lo) buf_q[wr_ptr] <= fetch_data_i[31:16];
        else begin
          buf_q[wr_ptr]          <= fetch_data_i[15:0];
          buf_q[wr_ptr + AW'(1)] <= fetch_data_i[31:16];
        end
        wr_ptr  <= wr_ptr + push_n;
        skip_lo <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + pop_n;
        pc     <= pc + (is32 ? 32'd4 : 32'd2);
      end
      count <= count + {1'b0, push_n} - {1'b0, pop_n};
    end
  end
endmodule

// File: tb/tb_instr_realigner.sv
module tb_instr_realigner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid, fetch_ready, redirect, instr_valid, instr_ready, comp, ill;
  logic [31:0] fetch_data, redirect_pc, instr, ipc;
  logic        fv2, fr2, rdy2, val2, comp2, ill2;
  logic [31:0] fd2, instr2, pc2;

  always #5 clk = ~clk;

  instr_realigner dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready), .fetch_data_i(fetch_data),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(ipc), .compressed_o(comp), .illegal_o(ill)
  );

  instr_realigner #(.ENABLE_C(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid_i(fv2), .fetch_ready_o(fr2), .fetch_data_i(fd2),
    .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .instr_valid_o(val2), .instr_ready_i(rdy2),
    .instr_o(instr2), .instr_pc_o(pc2), .compressed_o(comp2), .illegal_o(ill2)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
    logic        ill;
  } out_t;

  typedef struct {
    logic [15:0] parcel;
    logic [31:0] instr;
    logic        ill;
  } vec_t;

  int          checks = 0, failures = 0;
  logic [31:0] words[$];
  out_t        exp_q[$];
  vec_t        vt[18];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] i, input logic [31:0] pc, input logic c, input logic il);
    out_t e;
    e.instr = i; e.pc = pc; e.c = c; e.ill = il;
    exp_q.push_back(e);
  endtask

  function automatic out_t cur_out();
    out_t o;
    o.instr = instr; o.pc = ipc; o.c = comp; o.ill = ill;
    return o;
  endfunction

  // One cycle, entered and left on a negedge. Handshakes seen at negedge+1
  // are the ones that complete at the following posedge.
  task automatic tick(input logic rdy);
    out_t e;
    fetch_valid = (words.size() != 0);
    fetch_data  = fetch_valid ? words[0] : 32'h0;
    instr_ready = rdy;
    #1;
    if (fetch_valid && fetch_ready) void'(words.pop_front());
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: got %h expected no output", cur_out());
      end else begin
        e = exp_q.pop_front();
        chk("sb_out", cur_out(), e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || words.size() != 0) && n < 300) begin
      tick($urandom_range(0, 3) != 0);
      n++;
    end
    chk({name, "_drained"}, 96'(exp_q.size() + words.size()), 96'd0);
    exp_q.delete();
    words.delete();
    fetch_valid = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    fetch_valid = 1'b0;
    instr_ready = 1'b0;
    #1;
    chk("redir_fready", fetch_ready, 0);
    @(negedge clk);
    redirect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t snap;
    vt[0]  = '{16'h4515, 32'h0050_0513, 1'b0};
    vt[1]  = '{16'h0001, 32'h0000_0013, 1'b0};
    vt[2]  = '{16'h8082, 32'h0000_8067, 1'b0};
    vt[3]  = '{16'h0000, 32'h0000_0000, 1'b1};
    vt[4]  = '{16'h0040, 32'h0041_0413, 1'b0};
    vt[5]  = '{16'h41C8, 32'h0045_A503, 1'b0};
    vt[6]  = '{16'hC1C8, 32'h00A5_A223, 1'b0};
    vt[7]  = '{16'hBFFD, 32'hFFFF_F06F, 1'b0};
    vt[8]  = '{16'hC401, 32'h0004_0463, 1'b0};
    vt[9]  = '{16'h6281, 32'h0000_6281, 1'b1};
    vt[10] = '{16'h6141, 32'h0101_0113, 1'b0};
    vt[11] = '{16'h9005, 32'h0000_9005, 1'b1};
    vt[12] = '{16'h8C05, 32'h4094_0433, 1'b0};
    vt[13] = '{16'h4002, 32'h0000_4002, 1'b1};
    vt[14] = '{16'hC22A, 32'h00A1_2223, 1'b0};
    vt[15] = '{16'h952E, 32'h00B5_0533, 1'b0};
    vt[16] = '{16'h9002, 32'h0010_0073, 1'b0};
    vt[17] = '{16'h2000, 32'h0000_2000, 1'b1};

    rst_n = 1'b0; fetch_valid = 1'b0; fetch_data = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;
    fv2 = 1'b0; fd2 = 32'h0; rdy2 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_fready", fetch_ready, 1);
    chk("rst_instr", instr, 0);
    chk("rst_pc", ipc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_valid", instr_valid, 0);
    @(negedge clk);

    // ENABLE_C=0: every non-11 parcel is delivered as illegal
    fv2 = 1'b1; fd2 = 32'h0001_4515;
    @(negedge clk);
    fv2 = 1'b0;
    #1;
    chk("nc_first", {val2, instr2, pc2, comp2, ill2}, {1'b1, 32'h0000_4515, 32'h0, 1'b1, 1'b1});
    rdy2 = 1'b1;
    @(negedge clk);
    #1;
    chk("nc_second", {val2, instr2, pc2, comp2, ill2}, {1'b1, 32'h0000_0001, 32'h2, 1'b1, 1'b1});
    rdy2 = 1'b0;
    @(negedge clk);

    // reset PC, single 32-bit instruction
    words.push_back(32'h0050_0513);
    sb_push(32'h0050_0513, 32'h0, 1'b0, 1'b0);
    drain("t1");

    // straddling 32-bit instruction
    do_redirect(32'h0);
    words.push_back(32'h0513_4515);
    words.push_back(32'h0001_0050);
    sb_push(32'h0050_0513, 32'h0, 1'b1, 1'b0);
    sb_push(32'h0050_0513, 32'h2, 1'b0, 1'b0);
    sb_push(32'h0000_0013, 32'h6, 1'b1, 1'b0);
    drain("t2");

    // back-to-back redirects ending mid-word
    do_redirect(32'h100);
    do_redirect(32'h102);
    words.push_back(32'h8082_1234);
    sb_push(32'h0000_8067, 32'h102, 1'b1, 1'b0);
    drain("t3");

    // backpressure: hold decode off for 10 cycles
    do_redirect(32'h400);
    words.push_back(32'h0050_0513);
    words.push_back(32'h0001_4515);
    words.push_back(32'h0513_4515);
    words.push_back(32'h0001_0050);
    words.push_back(32'h952E_8082);
    sb_push(32'h0050_0513, 32'h400, 1'b0, 1'b0);
    sb_push(32'h0050_0513, 32'h404, 1'b1, 1'b0);
    sb_push(32'h0000_0013, 32'h406, 1'b1, 1'b0);
    sb_push(32'h0050_0513, 32'h408, 1'b1, 1'b0);
    sb_push(32'h0050_0513, 32'h40A, 1'b0, 1'b0);
    sb_push(32'h0000_0013, 32'h40E, 1'b1, 1'b0);
    sb_push(32'h0000_8067, 32'h410, 1'b1, 1'b0);
    sb_push(32'h00B5_0533, 32'h412, 1'b1, 1'b0);
    repeat (3) tick(1'b0);
    snap = cur_out();
    for (int i = 0; i < 7; i++) begin
      tick(1'b0);
      chk("t4_stable", cur_out(), snap);
    end
    chk("t4_fready_low", fetch_ready, 0);
    chk("t4_valid_held", instr_valid, 1);
    drain("t4");

    // illegal all-zero parcel
    do_redirect(32'h500);
    words.push_back(32'h4515_0000);
    sb_push(32'h0000_0000, 32'h500, 1'b1, 1'b1);
    sb_push(32'h0050_0513, 32'h502, 1'b1, 1'b0);
    drain("t5");

    // redirect coincident with fetch and output handshakes
    do_redirect(32'h200);
    words.push_back(32'h0050_0513);
    repeat (3) tick(1'b0);
    chk("t7_pre_valid", instr_valid, 1);
    redirect = 1'b1; redirect_pc = 32'h300;
    fetch_valid = 1'b1; fetch_data = 32'h1111_2222; instr_ready = 1'b1;
    #1;
    chk("t7_fready", fetch_ready, 0);
    @(negedge clk);
    redirect = 1'b0; fetch_valid = 1'b0; instr_ready = 1'b0;
    #1;
    chk("t7_flushed", instr_valid, 0);
    @(negedge clk);
    words.push_back(32'h0001_0001);
    sb_push(32'h0000_0013, 32'h300, 1'b1, 1'b0);
    sb_push(32'h0000_0013, 32'h302, 1'b1, 1'b0);
    drain("t7");

    // RVC expansion table, two parcels per fetch word
    do_redirect(32'h600);
    for (int i = 0; i < 18; i += 2) begin
      words.push_back({vt[i+1].parcel, vt[i].parcel});
      sb_push(vt[i].instr,   32'h600 + 32'(2*i),     1'b1, vt[i].ill);
      sb_push(vt[i+1].instr, 32'h600 + 32'(2*i + 2), 1'b1, vt[i+1].ill);
    end
    drain("table");

    // PC wrap
    do_redirect(32'hFFFF_FFFE);
    words.push_back(32'h4515_1234);
    words.push_back(32'h0001_0001);
    sb_push(32'h0050_0513, 32'hFFFF_FFFE, 1'b1, 1'b0);
    sb_push(32'h0000_0013, 32'h0, 1'b1, 1'b0);
    sb_push(32'h0000_0013, 32'h2, 1'b1, 1'b0);
    drain("t8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
